// File: rtl/image_bram_reader_if.sv
// rtl/image_bram_reader_if.sv - memory read port and pixel stream bundle for image_bram_reader
interface image_bram_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
);
  logic                  rd_en_o;
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  logic [DATA_WIDTH-1:0] rd_data_i;
  logic [DATA_WIDTH-1:0] px_data_o;
  logic                  px_valid_o;
  logic                  px_ready_i;
  logic                  px_last_o;

  modport master (
    output rd_en_o, rd_addr_o, px_data_o, px_valid_o, px_last_o,
    input  rd_data_i, px_ready_i
  );

  modport slave (
    input  rd_en_o, rd_addr_o, px_data_o, px_valid_o, px_last_o,
    output rd_data_i, px_ready_i
  );
endinterface

// File: rtl/image_bram_reader.sv
// rtl/image_bram_reader.sv - streams one frame from the image BRAM read port onto a valid/ready pixel stream
module image_bram_reader #(
  parameter int    ADDR_DEPTH = 128,
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1,
  parameter string REGMODE    = "reg"
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  image_bram_reader_if.master bus
);

  localparam bit                    LP_REG  = (REGMODE == "reg");
  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(ADDR_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic                  r_fifo_last [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_valid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_push_last;
  logic                  w_rd_en;
  logic                  w_issue_last;
  logic                  w_inflight;
  logic                  w_head_last;
  logic                  w_busy;
  logic                  w_done;

  assign w_valid      = (r_count != 2'd0);
  assign w_pop        = w_valid & bus.px_ready_i;
  assign w_issue_last = (r_addr == LP_LAST);
  assign w_head_last  = r_fifo_last[r_rd_ptr];

  // In "noreg" mode the word lands in the FIFO in the issuing cycle, so nothing is ever in flight.
  assign w_inflight  = LP_REG ? r_inflight : 1'b0;
  assign w_push      = LP_REG ? r_inflight : w_rd_en;
  assign w_push_last = LP_REG ? r_inflight_last : w_issue_last;

  // Only issue when the word is guaranteed a FIFO slot on return, counting this cycle's pop.
  always_comb begin
    w_rd_en = 1'b0;
    if (r_state == ST_ISSUE) begin
      w_rd_en = ({1'b0, r_count} + {2'b00, w_inflight}) < (3'd2 + {2'b00, w_pop});
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_busy = 1'b1;
        if (w_rd_en && w_issue_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
        if (w_pop && w_head_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || r_state == ST_IDLE) begin
      r_addr <= '0;
    end else if (w_rd_en && !w_issue_last) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_issue_last;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= bus.rd_data_i;
        r_fifo_last[r_wr_ptr] <= w_push_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign bus.rd_en_o    = w_rd_en;
  assign bus.rd_addr_o  = r_addr;
  assign bus.px_data_o  = r_fifo_data[r_rd_ptr];
  assign bus.px_valid_o = w_valid;
  assign bus.px_last_o  = w_valid & w_head_last;
  assign busy_o         = w_busy;
  assign done_o         = w_done;

endmodule

// File: tb/tb_image_bram_reader.sv
// tb/tb_image_bram_reader.sv - self-checking bench for image_bram_reader in reg, noreg and single-word configurations
module tb_image_bram_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start;
  logic ready;
  logic busy_r, busy_n, busy_1;
  logic done_r, done_n, done_1;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [7:0] mem [128];

  int   depth     [3] = '{128, 128, 1};
  int   exp_idx   [3];
  int   iss_idx   [3];
  int   outst     [3];
  int   frames    [3];
  logic prev_stall[3];
  logic [7:0] prev_data[3];
  logic prev_last [3];

  image_bram_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(7)) if_reg ();
  image_bram_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(7)) if_noreg ();
  image_bram_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) if_one ();

  image_bram_reader #(.ADDR_DEPTH(128), .DATA_WIDTH(8), .ADDR_WIDTH(7), .REGMODE("reg")) u_reg (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy_r), .done_o(done_r), .bus(if_reg.master));
  image_bram_reader #(.ADDR_DEPTH(128), .DATA_WIDTH(8), .ADDR_WIDTH(7), .REGMODE("noreg")) u_noreg (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy_n), .done_o(done_n), .bus(if_noreg.master));
  image_bram_reader #(.ADDR_DEPTH(1), .DATA_WIDTH(8), .ADDR_WIDTH(1), .REGMODE("reg")) u_one (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy_1), .done_o(done_1), .bus(if_one.master));

  assign if_reg.px_ready_i   = ready;
  assign if_noreg.px_ready_i = ready;
  assign if_one.px_ready_i   = ready;

  // Memory read ports: registered for the "reg" instances, combinational for "noreg".
  always @(posedge clk) if (if_reg.rd_en_o) if_reg.rd_data_i <= mem[if_reg.rd_addr_o];
  always @(posedge clk) if (if_one.rd_en_o) if_one.rd_data_i <= mem[{6'd0, if_one.rd_addr_o}];
  assign if_noreg.rd_data_i = mem[if_noreg.rd_addr_o];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
  endtask

  // Reference model: each frame is mem[0..depth-1] in order, last flag on the final word,
  // reads issued in address order, never more than two words outstanding.
  task automatic mon(input int k, input logic v, input logic [7:0] d, input logic l,
                     input logic en, input int addr);
    if (rst) begin
      exp_idx[k] = 0; iss_idx[k] = 0; outst[k] = 0; prev_stall[k] = 1'b0;
      return;
    end
    if (prev_stall[k]) begin
      check($sformatf("hold_data%0d", k), 32'(d), 32'(prev_data[k]));
      check($sformatf("hold_last%0d", k), 32'(l), 32'(prev_last[k]));
    end
    if (en) begin
      check($sformatf("addr_order%0d", k), 32'(addr), 32'(iss_idx[k]));
      iss_idx[k] = (iss_idx[k] + 1) % depth[k];
      outst[k]++;
    end
    if (v && ready) begin
      check($sformatf("data%0d", k), 32'(d), 32'(mem[exp_idx[k]]));
      check($sformatf("last%0d", k), 32'(l), 32'(exp_idx[k] == depth[k] - 1));
      if (exp_idx[k] == depth[k] - 1) begin
        exp_idx[k] = 0;
        frames[k]++;
      end else begin
        exp_idx[k]++;
      end
      outst[k]--;
    end
    check($sformatf("outstanding_le2_%0d", k), 32'(outst[k] <= 2), 32'd1);
    prev_stall[k] = v && !ready;
    prev_data[k]  = d;
    prev_last[k]  = l;
  endtask

  task automatic settle();
    #1;
    mon(0, if_reg.px_valid_o, if_reg.px_data_o, if_reg.px_last_o, if_reg.rd_en_o, 32'(if_reg.rd_addr_o));
    mon(1, if_noreg.px_valid_o, if_noreg.px_data_o, if_noreg.px_last_o, if_noreg.rd_en_o, 32'(if_noreg.rd_addr_o));
    mon(2, if_one.px_valid_o, if_one.px_data_o, if_one.px_last_o, if_one.rd_en_o, 32'(if_one.rd_addr_o));
  endtask

  task automatic adv();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  32'({busy_r, busy_n, busy_1}), 32'd0);
    check({tag, "_done"},  32'({done_r, done_n, done_1}), 32'd0);
    check({tag, "_rd_en"}, 32'({if_reg.rd_en_o, if_noreg.rd_en_o, if_one.rd_en_o}), 32'd0);
    check({tag, "_valid"}, 32'({if_reg.px_valid_o, if_noreg.px_valid_o, if_one.px_valid_o}), 32'd0);
    check({tag, "_last"},  32'({if_reg.px_last_o, if_noreg.px_last_o, if_one.px_last_o}), 32'd0);
    check({tag, "_addr"},  32'({if_reg.rd_addr_o, if_noreg.rd_addr_o, if_one.rd_addr_o}), 32'd0);
    check({tag, "_data"},  32'({if_reg.px_data_o, if_noreg.px_data_o, if_one.px_data_o}), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    start = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      settle();
      adv();
    end
  endtask

  initial begin
    int c;
    int f0, f1, f2;
    bit hit;

    for (int k = 0; k < 3; k++) begin
      exp_idx[k] = 0; iss_idx[k] = 0; outst[k] = 0; frames[k] = 0;
      prev_stall[k] = 1'b0; prev_data[k] = 8'd0; prev_last[k] = 1'b0;
    end
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    fill_mem();
    adv();
    settle();
    adv();
    rst = 1'b0;
    settle();
    check_reset_values("reset");
    adv();

    // Full-rate frame, all three configurations side by side.
    for (c = 0; c <= 135; c++) begin
      start = (c == 0);
      ready = 1'b1;
      settle();
      check("reg_rd_en", 32'(if_reg.rd_en_o), 32'(c >= 1 && c <= 128));
      if (c >= 1 && c <= 128) check("reg_rd_addr", 32'(if_reg.rd_addr_o), 32'(c - 1));
      check("reg_valid", 32'(if_reg.px_valid_o), 32'(c >= 3 && c <= 130));
      check("reg_last",  32'(if_reg.px_last_o),  32'(c == 130));
      check("reg_busy",  32'(busy_r), 32'(c >= 1 && c <= 130));
      check("reg_done",  32'(done_r), 32'(c == 131));
      check("noreg_rd_en", 32'(if_noreg.rd_en_o), 32'(c >= 1 && c <= 128));
      check("noreg_valid", 32'(if_noreg.px_valid_o), 32'(c >= 2 && c <= 129));
      check("noreg_last",  32'(if_noreg.px_last_o),  32'(c == 129));
      check("noreg_busy",  32'(busy_n), 32'(c >= 1 && c <= 129));
      check("noreg_done",  32'(done_n), 32'(c == 130));
      check("one_rd_en", 32'(if_one.rd_en_o), 32'(c == 1));
      check("one_valid", 32'(if_one.px_valid_o), 32'(c == 3));
      check("one_last",  32'(if_one.px_last_o),  32'(c == 3));
      check("one_busy",  32'(busy_1), 32'(c >= 1 && c <= 3));
      check("one_done",  32'(done_1), 32'(c == 4));
      adv();
    end
    check("fullrate_frames", 32'({frames[0], frames[1], frames[2]} == {32'd1, 32'd1, 32'd1}), 32'd1);

    // Alternating backpressure, then random backpressure.
    for (int pass = 0; pass < 2; pass++) begin
      fill_mem();
      f0 = frames[0]; f1 = frames[1]; f2 = frames[2];
      for (c = 0; c < 1000; c++) begin
        start = (c == 0);
        ready = (pass == 0) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
        settle();
        adv();
        if (frames[0] != f0 && frames[1] != f1 && frames[2] != f2) break;
      end
      check($sformatf("bp%0d_frame_reg", pass),   32'(frames[0] - f0), 32'd1);
      check($sformatf("bp%0d_frame_noreg", pass), 32'(frames[1] - f1), 32'd1);
      check($sformatf("bp%0d_frame_one", pass),   32'(frames[2] - f2), 32'd1);
      idle_cycles(4);
    end

    // Long stall right after the first valid word.
    fill_mem();
    f0 = frames[0]; f1 = frames[1];
    start = 1'b1; ready = 1'b0;
    settle();
    adv();
    start = 1'b0;
    hit = 1'b0;
    for (c = 1; c < 10; c++) begin
      settle();
      if (if_reg.px_valid_o) begin
        hit = 1'b1;
        break;
      end
      adv();
    end
    check("stall_first_valid_cycle", 32'(c), 32'd3);
    for (int i = 0; i < 20; i++) begin
      if (i > 0 || !hit) settle();
      check("stall_reg_rd_en",   32'(if_reg.rd_en_o),   32'd0);
      check("stall_noreg_rd_en", 32'(if_noreg.rd_en_o), 32'd0);
      check("stall_reg_valid",   32'(if_reg.px_valid_o), 32'd1);
      check("stall_reg_outst",   32'(outst[0]), 32'd2);
      check("stall_noreg_outst", 32'(outst[1]), 32'd2);
      adv();
    end
    ready = 1'b1;
    for (c = 0; c < 400; c++) begin
      settle();
      adv();
      if (frames[0] != f0 && frames[1] != f1) break;
    end
    check("stall_frame_reg",   32'(frames[0] - f0), 32'd1);
    check("stall_frame_noreg", 32'(frames[1] - f1), 32'd1);
    idle_cycles(4);

    // Reset after word 50 of the reg instance has transferred.
    fill_mem();
    for (c = 0; c < 200; c++) begin
      start = (c == 0);
      ready = 1'b1;
      settle();
      adv();
      if (exp_idx[0] == 50) break;
    end
    check("midreset_reached_word50", 32'(exp_idx[0]), 32'd50);
    rst = 1'b1; ready = 1'b0;
    settle();
    adv();
    rst = 1'b0;
    settle();
    check_reset_values("midreset");
    adv();
    fill_mem();
    f0 = frames[0]; f1 = frames[1]; f2 = frames[2];
    for (c = 0; c < 1000; c++) begin
      start = (c == 0);
      ready = 1'($urandom_range(0, 1));
      settle();
      adv();
      if (frames[0] != f0 && frames[1] != f1 && frames[2] != f2) break;
    end
    check("after_reset_frame_reg",   32'(frames[0] - f0), 32'd1);
    check("after_reset_frame_noreg", 32'(frames[1] - f1), 32'd1);
    check("after_reset_frame_one",   32'(frames[2] - f2), 32'd1);
    idle_cycles(4);

    // start held high across a whole frame and through DONE.
    fill_mem();
    f0 = frames[0];
    start = 1'b1; ready = 1'b1;
    hit = 1'b0;
    for (c = 0; c < 300; c++) begin
      settle();
      if (done_r) begin
        hit = 1'b1;
        break;
      end
      adv();
    end
    check("held_done_seen", 32'(hit), 32'd1);
    check("held_done_busy",  32'(busy_r), 32'd0);
    check("held_done_rd_en", 32'(if_reg.rd_en_o), 32'd0);
    adv();
    settle();
    check("held_idle_rd_en", 32'(if_reg.rd_en_o), 32'd0);
    check("held_idle_busy",  32'(busy_r), 32'd0);
    adv();
    settle();
    check("held_restart_rd_en", 32'(if_reg.rd_en_o), 32'd1);
    check("held_restart_addr",  32'(if_reg.rd_addr_o), 32'd0);
    check("held_restart_busy",  32'(busy_r), 32'd1);
    adv();
    start = 1'b0;
    for (c = 0; c < 300; c++) begin
      settle();
      adv();
      if (frames[0] - f0 >= 2) break;
    end
    check("held_two_frames", 32'(frames[0] - f0), 32'd2);
    idle_cycles(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
